// File: rtl/prefetch_unit.sv
// prefetch_unit: sequential instruction prefetcher, one outstanding memory request,
// fetched words queued with their PC in a small FIFO toward the next stage.
module prefetch_unit #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int DEPTH = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    halt,
    input  logic                    redirect,
    input  logic [AW-1:0]           redirect_pc,
    output logic                    mem_en,
    output logic [AW-1:0]           mem_addr,
    input  logic [DW-1:0]           mem_do,
    input  logic                    mem_do_ack,
    output logic                    DOR,
    output logic [DW-1:0]           data_out,
    output logic [AW-1:0]           pc_out,
    input  logic                    ack_from_next,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_pc, r_addr;
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_data [DEPTH];
    logic [AW-1:0] r_tag [DEPTH];
    logic          w_issue, w_push, w_pop;

    // Issuing only below FULL keeps a slot free for the single outstanding request.
    always_comb begin
        w_issue = (r_state == IDLE) && !halt && !redirect && (r_cnt < FULL);
        w_push  = (r_state == REQ) && mem_do_ack && !redirect;
        w_pop   = (r_cnt != '0) && ack_from_next && !redirect;
        w_next  = (r_state == IDLE) ? (w_issue ? REQ : IDLE) :
                  mem_do_ack        ? IDLE :
                  (r_state == REQ)  ? (redirect ? DISCARD : REQ) : DISCARD;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_issue) r_addr <= r_pc;
            if (redirect) begin
                r_pc  <= redirect_pc;
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_pc <= r_pc + AW'(1);
                    r_wp <= r_wp + PW'(1);
                end
                if (w_pop) r_rp <= r_rp + PW'(1);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && w_push) begin
            r_data[r_wp] <= mem_do;
            r_tag[r_wp]  <= r_pc;
        end
    end

    assign mem_en   = (r_state != IDLE);
    assign mem_addr = r_addr;
    assign DOR      = (r_cnt != '0);
    assign data_out = DOR ? r_data[r_rp] : '0;
    assign pc_out   = DOR ? r_tag[r_rp] : '0;
    assign count    = r_cnt;
endmodule

// File: tb/tb_prefetch_unit.sv
// tb_prefetch_unit: directed vector table plus hand sequences for prefetch_unit;
// a second instance with RESET_PC=FE shares the inputs to exercise address wrap.
module tb_prefetch_unit;
    logic       clk = 0;
    logic       reset_n = 0, halt = 0, redirect = 0, mem_do_ack = 0, ack_from_next = 0;
    logic [7:0] redirect_pc = 0, mem_do = 0, mem_do_b = 0;
    logic       mem_en, dor, mem_en_b, dor_b;
    logic [7:0] mem_addr, data_out, pc_out, mem_addr_b, data_out_b, pc_out_b;
    logic [2:0] count, count_b;

    int n_chk = 0, n_err = 0, age = 0;
    logic auto_mem = 0;
    logic [7:0]  log_a[$], log_b[$];
    logic [15:0] pops_b[$];

    prefetch_unit #(.AW(8), .DW(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_do(mem_do), .mem_do_ack(mem_do_ack),
        .DOR(dor), .data_out(data_out), .pc_out(pc_out), .ack_from_next(ack_from_next), .count(count));

    prefetch_unit #(.AW(8), .DW(8), .DEPTH(4), .RESET_PC(8'hFE)) dut_b (
        .clk(clk), .reset_n(reset_n), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_do(mem_do_b), .mem_do_ack(mem_do_ack),
        .DOR(dor_b), .data_out(data_out_b), .pc_out(pc_out_b), .ack_from_next(ack_from_next), .count(count_b));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       halt;
        logic       rd;
        logic [7:0] rpc;
        logic       ack;
        logic [7:0] dat;
        logic       nxt;
        logic       en;
        logic [7:0] addr;
        logic       dor;
        logic [7:0] dout;
        logic [7:0] pc;
        logic [2:0] cnt;
    } vec_t;
    vec_t tbl [22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // The automatic responder acks in the second cycle of each request.
    task automatic tick();
        if (auto_mem) begin
            mem_do_ack = mem_en && age >= 2;
            mem_do     = mem_addr + 8'h10;
            mem_do_b   = mem_addr_b + 8'h10;
        end
        if (reset_n && !redirect && dor_b && ack_from_next) pops_b.push_back({pc_out_b, data_out_b});
        @(posedge clk);
        #1;
        age = mem_en ? age + 1 : 0;
        if (mem_en && age == 1) begin
            log_a.push_back(mem_addr);
            log_b.push_back(mem_addr_b);
        end
    endtask

    task automatic do_reset();
        {halt, redirect, mem_do_ack, ack_from_next, auto_mem} = '0;
        redirect_pc = 0;
        mem_do = 0;
        reset_n = 0;
        tick();
        tick();
        chk("rst mem_en", 32'(mem_en), 0);
        chk("rst mem_addr", 32'(mem_addr), 0);
        chk("rst mem_addr_b", 32'(mem_addr_b), 32'h FE);
        chk("rst DOR", 32'(dor), 0);
        chk("rst count", 32'(count), 0);
        chk("rst data_out", 32'(data_out), 0);
        chk("rst pc_out", 32'(pc_out), 0);
        reset_n = 1;
        age = 0;
        log_a.delete();
        log_b.delete();
        pops_b.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          halt  rd    rpc    ack   dat    nxt   en    addr   dor   dout   pc     cnt
        tbl[0]  = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,8'h00,1'b0,8'h00,8'h00,3'd0};
        tbl[1]  = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,8'h00,1'b0,8'h00,8'h00,3'd0};
        tbl[2]  = '{1'b0,1'b0,8'h00,1'b1,8'h10,1'b1,1'b0,8'h00,1'b1,8'h10,8'h00,3'd1};
        tbl[3]  = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,8'h01,1'b0,8'h00,8'h00,3'd0};
        tbl[4]  = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,8'h01,1'b0,8'h00,8'h00,3'd0};
        tbl[5]  = '{1'b0,1'b0,8'h00,1'b1,8'h11,1'b1,1'b0,8'h01,1'b1,8'h11,8'h01,3'd1};
        tbl[6]  = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,8'h02,1'b0,8'h00,8'h00,3'd0};
        tbl[7]  = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,8'h02,1'b0,8'h00,8'h00,3'd0};
        tbl[8]  = '{1'b0,1'b0,8'h00,1'b1,8'h12,1'b0,1'b0,8'h02,1'b1,8'h12,8'h02,3'd1};
        tbl[9]  = '{1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h02,1'b1,8'h12,8'h02,3'd1};
        tbl[10] = '{1'b1,1'b0,8'h00,1'b0,8'h00,1'b1,1'b0,8'h02,1'b0,8'h00,8'h00,3'd0};
        tbl[11] = '{1'b1,1'b0,8'h00,1'b1,8'h55,1'b1,1'b0,8'h02,1'b0,8'h00,8'h00,3'd0};
        tbl[12] = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,8'h03,1'b0,8'h00,8'h00,3'd0};
        tbl[13] = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,8'h03,1'b0,8'h00,8'h00,3'd0};
        tbl[14] = '{1'b1,1'b0,8'h00,1'b1,8'h13,1'b1,1'b0,8'h03,1'b1,8'h13,8'h03,3'd1};
        tbl[15] = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,8'h04,1'b1,8'h13,8'h03,3'd1};
        tbl[16] = '{1'b1,1'b0,8'h00,1'b1,8'h14,1'b0,1'b0,8'h04,1'b1,8'h13,8'h03,3'd2};
        tbl[17] = '{1'b0,1'b1,8'h20,1'b0,8'h00,1'b0,1'b0,8'h04,1'b0,8'h00,8'h00,3'd0};
        tbl[18] = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,8'h20,1'b0,8'h00,8'h00,3'd0};
        tbl[19] = '{1'b0,1'b1,8'h30,1'b1,8'h77,1'b0,1'b0,8'h20,1'b0,8'h00,8'h00,3'd0};
        tbl[20] = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,8'h30,1'b0,8'h00,8'h00,3'd0};
        tbl[21] = '{1'b0,1'b0,8'h00,1'b1,8'h40,1'b0,1'b0,8'h30,1'b1,8'h40,8'h30,3'd1};

        do_reset();
        for (int i = 0; i < 22; i++) begin
            halt = tbl[i].halt;
            redirect = tbl[i].rd;
            redirect_pc = tbl[i].rpc;
            mem_do_ack = tbl[i].ack;
            mem_do = tbl[i].dat;
            ack_from_next = tbl[i].nxt;
            tick();
            chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(tbl[i].en));
            chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            chk($sformatf("v%0d DOR", i), 32'(dor), 32'(tbl[i].dor));
            chk($sformatf("v%0d data_out", i), 32'(data_out), 32'(tbl[i].dout));
            chk($sformatf("v%0d pc_out", i), 32'(pc_out), 32'(tbl[i].pc));
            chk($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].cnt));
        end

        // FIFO fills to DEPTH, issue stalls, one pop re-enables fetching
        do_reset();
        auto_mem = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("full nreq", 32'(log_a.size()), 4);
        for (int i = 0; i < 4 && i < log_a.size(); i++) chk($sformatf("full addr%0d", i), 32'(log_a[i]), 32'(i));
        chk("full count", 32'(count), 4);
        chk("full mem_en", 32'(mem_en), 0);
        chk("full head pc", 32'(pc_out), 0);
        chk("full head data", 32'(data_out), 32'h10);
        ack_from_next = 1;
        tick();
        ack_from_next = 0;
        chk("pop count", 32'(count), 3);
        chk("pop head pc", 32'(pc_out), 1);
        chk("pop head data", 32'(data_out), 32'h11);
        for (int k = 0; k < 2 && !mem_en; k++) tick();
        chk("refill mem_en", 32'(mem_en), 1);
        chk("refill addr", 32'(mem_addr), 4);

        // Redirect while the request for addr 2 is outstanding
        do_reset();
        auto_mem = 1;
        for (int k = 0; k < 20 && !(mem_en && mem_addr == 8'h02 && age == 1); k++) tick();
        chk("rdreq reached", 32'(mem_en && mem_addr == 8'h02), 1);
        auto_mem = 0;
        mem_do_ack = 0;
        redirect = 1;
        redirect_pc = 8'h40;
        tick();
        redirect = 0;
        chk("discard mem_en", 32'(mem_en), 1);
        chk("discard addr", 32'(mem_addr), 2);
        chk("discard count", 32'(count), 0);
        chk("discard DOR", 32'(dor), 0);
        tick();
        tick();
        chk("discard hold", 32'(mem_en), 1);
        mem_do_ack = 1;
        mem_do = 8'h99;
        tick();
        mem_do_ack = 0;
        chk("discard done mem_en", 32'(mem_en), 0);
        chk("discard dropped", 32'(count), 0);
        tick();
        chk("redir issue en", 32'(mem_en), 1);
        chk("redir issue addr", 32'(mem_addr), 32'h40);

        // Address and pointer wrap on the RESET_PC=FE instance
        do_reset();
        auto_mem = 1;
        ack_from_next = 1;
        for (int i = 0; i < 30; i++) tick();
        chk("wrap nreq", 32'(log_b.size() >= 4), 1);
        for (int i = 0; i < 4 && i < log_b.size(); i++)
            chk($sformatf("wrap addr%0d", i), 32'(log_b[i]), 32'(8'(8'hFE + i)));
        chk("wrap npop", 32'(pops_b.size() >= 8), 1);
        for (int i = 0; i < 8 && i < pops_b.size(); i++)
            chk($sformatf("wrap pop%0d", i), 32'(pops_b[i]), 32'({8'(8'hFE + i), 8'(8'h0E + i)}));

        // Push with pop at count 2, then redirect with pop at count 3
        do_reset();
        auto_mem = 1;
        for (int k = 0; k < 30 && !(count == 3'd2 && age == 2); k++) tick();
        chk("sim reached", 32'(count == 3'd2 && mem_do_ack == 1'b0 && age == 2), 1);
        ack_from_next = 1;
        tick();
        ack_from_next = 0;
        chk("sim count", 32'(count), 2);
        chk("sim head pc", 32'(pc_out), 1);
        chk("sim head data", 32'(data_out), 32'h11);
        for (int k = 0; k < 30 && count != 3'd3; k++) tick();
        chk("sim count3", 32'(count), 3);
        ack_from_next = 1;
        redirect = 1;
        redirect_pc = 8'h80;
        tick();
        ack_from_next = 0;
        redirect = 0;
        chk("rdpop count", 32'(count), 0);
        chk("rdpop DOR", 32'(dor), 0);
        for (int k = 0; k < 12 && !(mem_en && mem_addr == 8'h80); k++) tick();
        chk("rdpop next addr", 32'(mem_addr), 32'h80);

        // Reset during a request, then a late ack
        do_reset();
        auto_mem = 1;
        for (int k = 0; k < 20 && !(mem_en && mem_addr == 8'h01 && age == 1); k++) tick();
        chk("rstreq reached", 32'(mem_en && mem_addr == 8'h01), 1);
        auto_mem = 0;
        mem_do_ack = 0;
        reset_n = 0;
        redirect = 1;
        redirect_pc = 8'h44;
        ack_from_next = 1;
        tick();
        reset_n = 1;
        redirect = 0;
        ack_from_next = 0;
        halt = 1;
        chk("midrst mem_en", 32'(mem_en), 0);
        chk("midrst addr", 32'(mem_addr), 0);
        chk("midrst count", 32'(count), 0);
        chk("midrst DOR", 32'(dor), 0);
        mem_do_ack = 1;
        mem_do = 8'h77;
        tick();
        mem_do_ack = 0;
        chk("late ack count", 32'(count), 0);
        chk("late ack DOR", 32'(dor), 0);
        chk("halt mem_en", 32'(mem_en), 0);
        halt = 0;
        tick();
        chk("post rst en", 32'(mem_en), 1);
        chk("post rst addr", 32'(mem_addr), 0);
        chk("post rst addr_b", 32'(mem_addr_b), 32'hFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
